// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one result bit per cycle, {hi,lo} result with a done pulse.
// Signed operands are reduced to magnitudes at accept, and the signs are reapplied on the edge into DONE.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state | meaning
    // IDLE  | waiting for an op, results held
    // RUN   | iterating, one bit per cycle
    // DONE  | hi/lo valid, done pulse, may accept next op
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT              state, stateNext;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] work, workNext;
    logic [WIDTH-1:0]   opB;
    logic               isDiv, negLo, negHi;

    logic               accept, divByZero, lastIter, signedOp;
    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic [2*WIDTH-1:0] fullProd;
    logic [WIDTH-1:0]   quoFix, remFix;

    assign start_ready = ((state == IDLE) || (state == DONE)) && !flush;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    assign accept    = start_valid && start_ready;
    assign divByZero = op[1] && (src_b == '0);
    assign signedOp  = !op[0];
    assign lastIter  = (state == RUN) && (counter == CNT_W'(WIDTH - 1));
    assign magA      = (signedOp && src_a[WIDTH-1]) ? -src_a : src_a;
    assign magB      = (signedOp && src_b[WIDTH-1]) ? -src_b : src_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = divByZero ? DONE : RUN;
            RUN:     if (lastIter) stateNext = DONE;
            DONE:    if (accept) stateNext = divByZero ? DONE : RUN;
                     else        stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end

    // work = {partial product | remainder, multiplier | dividend->quotient}
    always_comb begin
        mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opB} : '0);
        divShift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        divDiff  = divShift - {1'b0, opB};
        if (isDiv) begin
            if (!divDiff[WIDTH]) workNext = {divDiff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else                 workNext = {divShift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end else begin
            workNext = {mulSum, work[WIDTH-1:1]};
        end
        fullProd = negLo ? -workNext : workNext;
        quoFix   = negLo ? -workNext[WIDTH-1:0] : workNext[WIDTH-1:0];
        remFix   = negHi ? -workNext[2*WIDTH-1:WIDTH] : workNext[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter <= '0;
            work    <= '0;
            opB     <= '0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (accept) begin
            counter <= '0;
            work    <= {{WIDTH{1'b0}}, magA};
            opB     <= magB;
            isDiv   <= op[1];
            negLo   <= signedOp && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            negHi   <= signedOp && op[1] && src_a[WIDTH-1];
            if (divByZero) begin
                hi <= src_a;
                lo <= '1;
            end
        end else if ((state == RUN) && !flush) begin
            counter <= counter + CNT_W'(1);
            work    <= workNext;
            if (lastIter) begin
                hi <= isDiv ? remFix : fullProd[2*WIDTH-1:WIDTH];
                lo <= isDiv ? quoFix : fullProd[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Caller is at a negedge; returns cycles from accept to the first done sample (-1 on timeout).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        op = o; src_a = a; src_b = b; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", start_ready);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops[7]  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] as[7]   = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h12345678};
        logic [31:0] bs[7]   = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
        logic [63:0] exps[7] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'h40000000_00000000,
                                 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003, 64'h00000000_80000000,
                                 64'h12345678_FFFFFFFF};
        int lat, expLat;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], lat);
            expLat = (i == 6) ? 1 : 33;
            checks++;
            if (lat != expLat || {hi, lo} !== exps[i]) begin
                failures++;
                $display("FAIL directed_%0d got lat=%0d hi=%h lo=%h want lat=%0d %h", i, lat, hi, lo, expLat, exps[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse_%0d got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_div_zero();
        op = 2'b11; src_a = 32'hCAFE0001; src_b = 32'd0; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== 32'hCAFE0001 || lo !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL divu_zero got busy=%b done=%b hi=%h lo=%h want 0 1 cafe0001 ffffffff", busy, done, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int lat = -1;
        op = 2'b01; src_a = 32'd7; src_b = 32'd6; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(negedge clk);
        op = 2'b11; src_a = 32'd100; src_b = 32'd3; start_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ready got ready=%b busy=%b want 0 1", start_ready, busy);
        end
        repeat (2) @(negedge clk);
        start_valid = 1'b0;
        for (int n = 9; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd42) begin
            failures++;
            $display("FAIL busy_ignore got lat=%0d hi=%h lo=%h want 33 0 2a", lat, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int lat, doneSeen = 0;
        logic [31:0] prevHi, prevLo;
        issue(2'b00, 32'hFFFFFFFD, 32'd5, lat);
        prevHi = hi; prevLo = lo;
        @(negedge clk);
        op = 2'b01; src_a = 32'h1234; src_b = 32'h5678; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start_valid = 1'b1;
        #1;
        checks++;
        if (start_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready got ready=%b busy=%b want 0 1", start_ready, busy);
        end
        @(posedge clk);
        #1 flush = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || start_ready !== 1'b1 || hi !== prevHi || lo !== prevLo) begin
            failures++;
            $display("FAIL flush_state got busy=%b done=%b ready=%b hi=%h lo=%h want 0 0 1 %h %h",
                     busy, done, start_ready, hi, lo, prevHi, prevLo);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checks++;
        if (doneSeen != 0 || hi !== prevHi || lo !== prevLo) begin
            failures++;
            $display("FAIL flush_no_done got active_cycles=%0d hi=%h lo=%h want 0 %h %h", doneSeen, hi, lo, prevHi, prevLo);
        end
    endtask

    task automatic test_reset_mid_run();
        op = 2'b10; src_a = 32'd1000; src_b = 32'd7; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failures++;
            $display("FAIL reset_mid_run got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b busy=%b want 1 0", start_ready, busy);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        int lat, expLat;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            exp = model(o, a, b);
            expLat = (o[1] && b == 0) ? 1 : 33;
            issue(o, a, b, lat);
            checks++;
            if (lat != expLat || {hi, lo} !== exp) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h want lat=%0d %h",
                         i, o, a, b, lat, hi, lo, expLat, exp);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [31:0] h1, l1;
        issue(2'b11, 32'd7, 32'd2, lat1);
        h1 = hi; l1 = lo;
        issue(2'b00, 32'hFFFFFFFD, 32'd5, lat2);
        checks++;
        if (lat1 != 33 || h1 !== 32'd1 || l1 !== 32'd3) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d hi=%h lo=%h want 33 1 3", lat1, h1, l1);
        end
        checks++;
        if (lat2 != 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d hi=%h lo=%h want 33 ffffffff fffffff1", lat2, hi, lo);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_busy_ignore();
        test_flush();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
